// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types and scan-code constants for the PS/2 key sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GOT_F0   = 2'd1,
        S_GOT_E0   = 2'd2,
        S_GOT_E0F0 = 2'd3
    } state_t;

    localparam logic [7:0] c_prefix_f0 = 8'hF0;
    localparam logic [7:0] c_prefix_e0 = 8'hE0;

    localparam logic [7:0] c_sc_w = 8'h1D;
    localparam logic [7:0] c_sc_a = 8'h1C;
    localparam logic [7:0] c_sc_s = 8'h1B;
    localparam logic [7:0] c_sc_d = 8'h23;
    localparam logic [7:0] c_sc_q = 8'h15;
    localparam logic [7:0] c_sc_e = 8'h24;
    localparam logic [7:0] c_sc_r = 8'h2D;
    localparam logic [7:0] c_sc_f = 8'h2B;
    localparam logic [7:0] c_sc_t = 8'h2C;

    localparam logic [3:0] c_key_w = 4'd0;
    localparam logic [3:0] c_key_a = 4'd1;
    localparam logic [3:0] c_key_s = 4'd2;
    localparam logic [3:0] c_key_d = 4'd3;
    localparam logic [3:0] c_key_q = 4'd4;
    localparam logic [3:0] c_key_e = 4'd5;
    localparam logic [3:0] c_key_r = 4'd6;
    localparam logic [3:0] c_key_f = 4'd7;
    localparam logic [3:0] c_key_t = 4'd8;

    typedef struct packed {
        logic       is_make;
        logic [3:0] key_idx;
    } evt_t;

    // Returns {hit, key_idx}; hit=0 for codes outside the game key set.
    function automatic logic [4:0] key_lookup(input logic [7:0] code);
        case (code)
            c_sc_w:  key_lookup = {1'b1, c_key_w};
            c_sc_a:  key_lookup = {1'b1, c_key_a};
            c_sc_s:  key_lookup = {1'b1, c_key_s};
            c_sc_d:  key_lookup = {1'b1, c_key_d};
            c_sc_q:  key_lookup = {1'b1, c_key_q};
            c_sc_e:  key_lookup = {1'b1, c_key_e};
            c_sc_r:  key_lookup = {1'b1, c_key_r};
            c_sc_f:  key_lookup = {1'b1, c_key_f};
            c_sc_t:  key_lookup = {1'b1, c_key_t};
            default: key_lookup = 5'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_sequencer_evt_fifo.sv
// ============================================================================
// Module   : evt_fifo
// Brief    : Small synchronous FIFO with valid/ready output side and full flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_empty;
    logic             w_pop;
    logic             w_wr_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                     (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    assign w_pop   = i_ready && !w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en = i_push && (!o_full || w_pop);

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_sequencer.sv
// ============================================================================
// Module   : ps2_key_sequencer
// Brief    : Frames PS/2 bytes into make/break pairs, tracks game-key state and
//            queues key-change events.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             byte_par_err,
    output logic [7:0]       code1,
    output logic [7:0]       code2,
    output logic             pair_valid,
    output logic [8:0]       key_state,
    output logic             evt_valid,
    output logic [4:0]       evt_data,
    input  logic             evt_ready,
    output logic             overflow,
    output logic [ERR_W-1:0] err_count,
    input  logic             clear
);

    localparam int                c_to_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYC);

    state_t            r_state, w_state_nxt;
    logic [c_to_w-1:0] r_to_cnt, w_to_nxt, w_to_inc;
    logic              w_frame_done;
    logic              w_is_break;
    logic              w_hit;
    logic [3:0]        w_idx;
    logic              w_held;
    logic              w_push;
    logic              w_full;
    evt_t              w_evt;
    logic [7:0]        r_code1, r_code2;
    logic              r_pair_valid;
    logic [8:0]        r_key_state;
    logic              r_overflow;
    logic [ERR_W-1:0]  r_err_cnt;

    assign w_to_inc = r_to_cnt + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_to_nxt     = '0;
        w_frame_done = 1'b0;
        w_is_break   = 1'b0;
        if (byte_valid) begin
            if (byte_par_err) begin
                w_state_nxt = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (byte_data == c_prefix_f0)      w_state_nxt = S_GOT_F0;
                        else if (byte_data == c_prefix_e0) w_state_nxt = S_GOT_E0;
                        else                               w_frame_done = 1'b1;
                    end
                    S_GOT_F0: begin
                        w_frame_done = 1'b1;
                        w_is_break   = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                    // Extended frames are swallowed without any visible effect.
                    S_GOT_E0:   w_state_nxt = (byte_data == c_prefix_f0) ? S_GOT_E0F0 : S_IDLE;
                    S_GOT_E0F0: w_state_nxt = S_IDLE;
                    default:    w_state_nxt = S_IDLE;
                endcase
            end
        end else if (r_state != S_IDLE) begin
            if (w_to_inc == c_to_max) w_state_nxt = S_IDLE;
            else                      w_to_nxt    = w_to_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_nxt;
        end
    end

    assign {w_hit, w_idx} = key_lookup(byte_data);
    assign w_held         = r_key_state[w_idx];
    // Only genuine state changes generate events; repeats and stray breaks do not.
    assign w_push         = w_frame_done && w_hit && (w_is_break ? w_held : !w_held);
    assign w_evt          = '{is_make: !w_is_break, key_idx: w_idx};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_code1      <= 8'h00;
            r_code2      <= 8'h00;
            r_pair_valid <= 1'b0;
            r_key_state  <= '0;
        end else begin
            r_pair_valid <= w_frame_done;
            if (w_frame_done) begin
                r_code1 <= w_is_break ? c_prefix_f0 : byte_data;
                r_code2 <= w_is_break ? byte_data : 8'h00;
                if (w_hit) r_key_state[w_idx] <= !w_is_break;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_push && w_full && !(evt_valid && evt_ready)) r_overflow <= 1'b1;
            if (byte_valid && byte_par_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(evt_t))
    ) u_evt_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_ready (evt_ready),
        .o_valid (evt_valid),
        .o_data  (evt_data),
        .o_full  (w_full)
    );

    assign code1      = r_code1;
    assign code2      = r_code2;
    assign pair_valid = r_pair_valid;
    assign key_state  = r_key_state;
    assign overflow   = r_overflow;
    assign err_count  = r_err_cnt;

endmodule

`default_nettype wire

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
Sits between the PS/2 byte receiver and the scan-code decoder stage. Assembles received bytes into make/break frames (F0 break prefix, E0 extended prefix), presents registered code1/code2 pairs to the decoder, and tracks held/released state for the nine game keys. Queues key-change events in a small FIFO for the game controller to consume with a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 50000, idle cycles after a prefix byte before the frame is abandoned (1 ms at 50 MHz)
ERR_W, 8, width of saturating parity-error counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
byte_valid  in  1  one-cycle strobe, new byte from PS/2 receiver
byte_data  in  8  received scan byte
byte_par_err  in  1  parity error flag, qualified by byte_valid
code1  out  8  to decoder: scancode (make) or 8'hF0 (break)
code2  out  8  to decoder: 8'h00 (make) or scancode (break)
pair_valid  out  1  one-cycle strobe, code1/code2 hold a complete frame
key_state  out  9  1 = held; bit order W,A,S,D,Q,E,R,F,T (bit0..bit8)
evt_valid  out  1  FIFO head valid
evt_data  out  5  {is_make, key_idx[3:0]}
evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
overflow  out  1  sticky: event dropped on full FIFO
err_count  out  ERR_W  saturating count of parity-error bytes
clear  in  1  synchronous clear of overflow and err_count

Behaviour:
- Reset (async, reset_n=0): state IDLE; code1=code2=8'h00; pair_valid=0; key_state=0; FIFO empty, evt_valid=0, evt_data=0; overflow=0; err_count=0; timeout counter=0.
- FSM states: IDLE, GOT_F0, GOT_E0, GOT_E0F0. Transitions on byte_valid & !byte_par_err:
  IDLE: F0->GOT_F0; E0->GOT_E0; other byte = normal make, stay IDLE.
  GOT_F0: any byte = normal break, ->IDLE.
  GOT_E0: F0->GOT_E0F0; other = extended make, ->IDLE.
  GOT_E0F0: any byte = extended break, ->IDLE.
- Extended frames consumed silently: no pair_valid, no key_state change, no event.
- Key map: 1D W=0, 1C A=1, 1B S=2, 23 D=3, 15 Q=4, 24 E=5, 2D R=6, 2B F=7, 2C T=8; other codes are "unmapped".
- Normal frame complete in cycle N -> cycle N+1: code1/code2 updated, pair_valid=1 for exactly one cycle (mapped and unmapped codes alike); key_state bit set (make) or cleared (break) for mapped keys.
- Event pushed only when a mapped key's state actually changes; typematic repeat makes (key already held) and breaks of unheld keys push nothing. Event visible at N+1 when FIFO was empty.
- Parity error byte: discarded, FSM ->IDLE, err_count += 1 saturating at all-ones; no pair_valid.
- Timeout: in any non-IDLE state, counter increments each cycle without byte_valid; at TIMEOUT_CYC ->IDLE, frame dropped. Counter cleared on byte_valid and in IDLE.
- FIFO: pop when evt_valid & evt_ready; push when full and no pop that cycle -> event dropped, overflow=1. Full with simultaneous pop: push accepted. Empty with push: no same-cycle bypass.
- evt_data stable while evt_valid & !evt_ready.
- clear has priority over same-cycle error increment/overflow set (result 0).
- byte_valid with FSM mid-frame behaves per table; no back-pressure to receiver.

Decomposition:
- Package ps2_pkg: state enum, prefix constants (F0, E0), nine scancode constants, key index constants, event struct {is_make, key_idx}.
- Sub-module evt_fifo (parameterised sync FIFO, depth FIFO_DEPTH, width 5, valid/ready out, full flag).

Test Plan:
- Bytes 1D, then F0,1D (evt_ready=1) -> pair (1D,00) then (F0,1D); key_state[0] 1 then 0; events 5'b1_0000, 5'b0_0000.
- 1C repeated 3x -> 3 pair_valid strobes, key_state[1]=1, exactly one event 5'b1_0001.
- E0,75 then E0,F0,75 -> no pair_valid, no events, FSM back to IDLE; key_state unchanged.
- evt_ready=0, make W,A,S,D,Q (5 changes, depth 4) -> 4 queued, overflow=1; drain -> W,A,S,D order; clear -> overflow=0.
- F0 then no byte for TIMEOUT_CYC cycles, then 23 -> treated as make D (1, not break), event 5'b1_0011.
- Byte 1D with par_err, then 1D clean -> err_count=1, single event; reset_n low mid-GOT_F0 -> all outputs to reset values immediately.
